// File: rtl/bram_pkg.sv
// ============================================================================
// Module      : bram_pkg
// Description : Shared constants and the depth helper for the bram block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_pkg;

  localparam int BRAM_DEFAULT_DATA_WIDTH = 8;
  localparam int BRAM_DEFAULT_ADDR_WIDTH = 4;

  // Depth is always the full address space; there is no partial array.
  function automatic int bram_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage : bram_pkg

`default_nettype wire

// File: rtl/bram_out_stage.sv
// ============================================================================
// Module      : bram_out_stage
// Description : Optional pipeline register behind the RAM read port; loads
//               every cycle and clears to zero on synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_out_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule : bram_out_stage

`default_nettype wire

// File: rtl/bram.sv
// ============================================================================
// Module      : bram
// Description : Single-port synchronous block RAM, shared address, registered
//               read, write-wins on simultaneous enables. Contents survive
//               reset. Define BRAM_OUT_REG_EN for an extra output register
//               (read latency 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = BRAM_DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = BRAM_DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = bram_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // No reset on the array so the tool can map it onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && write_enable) begin
      r_mem[address] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (read_enable && !write_enable) begin
      r_rd_data <= r_mem[address];
    end
  end

`ifdef BRAM_OUT_REG_EN
  bram_out_stage #(
    .WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .clk (clk),
    .rst (rst),
    .d   (r_rd_data),
    .q   (data_out)
  );
`else
  assign data_out = r_rd_data;
`endif

endmodule : bram

`default_nettype wire

// File: tb/tb_bram.sv
// ============================================================================
// Module      : tb_bram
// Description : Self-checking bench for bram: directed vector table followed
//               by randomized traffic against a behavioural memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram;
  import bram_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = bram_depth(AW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we  = 1'b0;
  logic          re  = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din  = '0;
  logic [DW-1:0] dout;

  always #5 clk = ~clk;

  bram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (we),
    .read_enable  (re),
    .address      (addr),
    .data_in      (din),
    .data_out     (dout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // exp = value of data_out right after this edge for a single-register read
  typedef struct {
    bit            r;
    bit            w;
    bit            rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: word store plus "last word read" and visible output
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  logic [DW-1:0] m_read;
  bit            m_read_k;
  logic [DW-1:0] m_vis;
  bit            m_vis_k;

  task automatic add(bit r, bit w, bit rd, int a, int d, int e);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd;
    v.a = AW'(a); v.d = DW'(d); v.exp = DW'(e);
    tbl.push_back(v);
  endtask

  task automatic model_step(bit r, bit w, bit rd, logic [AW-1:0] a, logic [DW-1:0] d);
    logic [DW-1:0] prev;
    bit            prev_k;
    prev   = m_read;
    prev_k = m_read_k;
    if (r) begin
      m_read   = '0;
      m_read_k = 1'b1;
    end else if (w) begin
      m_mem[a]   = d;
      m_known[a] = 1'b1;
    end else if (rd) begin
      m_read   = m_mem[a];
      m_read_k = m_known[a];
    end
`ifdef BRAM_OUT_REG_EN
    m_vis   = r ? '0 : prev;
    m_vis_k = r ? 1'b1 : prev_k;
`else
    m_vis   = m_read;
    m_vis_k = m_read_k;
`endif
  endtask

  task automatic drive(bit r, bit w, bit rd, logic [AW-1:0] a, logic [DW-1:0] d);
    @(negedge clk);
    rst = r; we = w; re = rd; addr = a; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, int idx, logic [DW-1:0] exp);
    n_cmp++;
    if (dout !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: data_out=%h expected=%h", nm, idx, dout, exp);
    end
  endtask

  initial begin
    logic [DW-1:0] e;
    logic [DW-1:0] prev_exp;
    bit            r, w, rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    m_read = '0; m_read_k = 1'b0; m_vis = '0; m_vis_k = 1'b0;

    // Reset with a read pending, then write/read 0xA5 at address 3
    add(1, 0, 1, 0, 0, 'h00);
    add(0, 1, 0, 3, 'hA5, 'h00);
    add(0, 0, 1, 3, 0, 'hA5);
    // Fill with i*17 then read back-to-back
    for (int i = 0; i < DEPTH; i++) add(0, 1, 0, i, i * 17, 'hA5);
    for (int i = 0; i < DEPTH; i++) add(0, 0, 1, i, 0, i * 17);
    // Write wins over read; later read returns the new word
    add(0, 0, 1, 1, 0, 'h11);
    add(0, 1, 1, 5, 'h3C, 'h11);
    add(0, 0, 1, 5, 0, 'h3C);
    // Hold with read disabled and a moving address
    add(0, 0, 1, 2, 0, 'h22);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 7, 0, 'h22);
    // Reset in the middle of a read stream keeps memory
    add(0, 0, 1, 8, 0, 'h88);
    add(1, 0, 1, 9, 0, 'h00);
    add(0, 0, 1, 9, 0, 'h99);
    add(0, 0, 1, 10, 0, 'hAA);
    // Boundary addresses
    add(0, 1, 0, 15, 'hFE, 'hAA);
    add(0, 1, 0, 0, 'h01, 'hAA);
    add(0, 0, 1, 15, 0, 'hFE);
    add(0, 0, 1, 0, 0, 'h01);

    prev_exp = '0;
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].a, tbl[i].d);
      model_step(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].a, tbl[i].d);
`ifdef BRAM_OUT_REG_EN
      e = tbl[i].r ? '0 : prev_exp;
`else
      e = tbl[i].exp;
`endif
      check("vec", i, e);
      prev_exp = tbl[i].exp;
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 24) == 0);
      w  = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 3) != 0);
      a  = AW'($urandom_range(0, DEPTH - 1));
      d  = DW'($urandom);
      drive(r, w, rd, a, d);
      model_step(r, w, rd, a, d);
      if (m_vis_k) check("rand", i, m_vis);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_bram

`default_nettype wire

// File: doc/bram.md
# bram

Single-port synchronous block RAM with a registered read port, one address bus shared by reads and writes, and separate write and read enables. It is a generic storage primitive for buffers, lookup tables and test data stores. It maps onto FPGA block RAM, so memory contents are never cleared by reset.

## Interface
- `DATA_WIDTH`, default 8: word width in bits.
- `ADDR_WIDTH`, default 4: address width in bits.
- `DEPTH`, default `1 << ADDR_WIDTH` (16): number of words. It is derived from `ADDR_WIDTH` and must not be overridden independently.

Ports:
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `write_enable`  in  1: write strobe.
- `read_enable`  in  1: read strobe.
- `address`  in  `ADDR_WIDTH`: word address, shared by reads and writes.
- `data_in`  in  `DATA_WIDTH`: write data.
- `data_out`  out  `DATA_WIDTH`: registered read data.

## Operation
- Storage is an array `mem[0:DEPTH-1]` of `DATA_WIDTH`-bit words.
- Reset:
  - On a rising edge with `rst`=1, `data_out` goes to 0.
  - Reads and writes are ignored on that edge.
  - `mem` is not cleared.
- Write: on a rising edge with `rst`=0 and `write_enable`=1, `mem[address] <= data_in`.
- Read: on a rising edge with `rst`=0, `read_enable`=1 and `write_enable`=0, `data_out <= mem[address]`.
- Write and read enables both high: the write wins. `mem[address]` is updated, no read occurs and `data_out` holds.
- Idle (`read_enable`=0): `data_out` holds its last value. It does not return to 0.
- Address range: every `ADDR_WIDTH` value is a valid address, so there is no out-of-range case and no wrap logic.
- Power-up contents are undefined (X in simulation). Reading a never-written word returns X.

## Timing
- Write latency:
  - Data is stored on the edge where `write_enable` is sampled high.
  - A read issued on the next cycle returns the new value.
- Read latency:
  - `address` and `read_enable` are sampled on edge N; `data_out` is valid after edge N and stable until edge N+1.
  - With `BRAM_OUT_REG_EN` defined, valid data appears after edge N+1 instead.
- Throughput: one access per cycle. Back-to-back reads to different addresses give one word per cycle.
- Reset mid-operation:
  - Any access coinciding with `rst`=1 is dropped.
  - The optional output stage also clears to 0.
- There is no handshake and no backpressure.

## Configuration
- `BRAM_OUT_REG_EN` undefined: one read register, read latency 1.
- `BRAM_OUT_REG_EN` defined:
  - A second register sits between the array output and `data_out`, for timing closure. Read latency is 2.
  - The second stage loads every cycle from the first stage.
  - Both stages reset to 0.
  - Hold and write-priority rules apply to the first stage.

## Structure
- Package `bram_pkg`:
  - constants `BRAM_DEFAULT_DATA_WIDTH` = 8 and `BRAM_DEFAULT_ADDR_WIDTH` = 4;
  - a function `bram_depth(addr_width)` returning `1 << addr_width`.
- Sub-module `bram_out_stage`:
  - the parameterised optional pipeline register, with `clk`, `rst`, `d` and `q` ports;
  - instantiated only under `BRAM_OUT_REG_EN`.
- The array is inferred with no vendor primitive, so the tool can map it to block RAM.

## Test plan
1. Reset: hold `rst`=1 for one edge with `read_enable`=1 -> `data_out`=0. Release `rst`, write 0xA5 to address 3 and read address 3 -> `data_out`=0xA5 one cycle after the read is sampled.
2. Fill and read back: write `i*17` (0x00, 0x11, … 0xFF) to addresses 0..15 on consecutive cycles, then read 0..15 back-to-back -> each word appears at latency 1 (latency 2 with the macro).
3. Write priority: `data_out`=0x11, then assert both enables at address 5 with `data_in`=0x3C -> `data_out` stays 0x11. A later read of address 5 returns 0x3C.
4. Hold: read address 2 (0x22), then deassert `read_enable` and change `address` to 7 for 3 cycles -> `data_out` stays 0x22.
5. Reset mid-stream: during back-to-back reads, assert `rst` for one cycle -> `data_out`=0 on that edge. A subsequent read of address 9 still returns 0x99, because memory is preserved.
6. Boundary addresses: write 0xFE to address 15 and 0x01 to address 0, then read both -> 0xFE and 0x01, with no aliasing between them.
